mac_array_stream: RTL
=====================

# mac_array_stream

Parametrised, handshaked successor to the fixed 4-lane 8-bit MAC array core. It computes LANES independent signed dot products of programmable length k_len, consuming one operand beat per accepted cycle and returning all lane accumulators together through a valid/ready output. It sits under the accelerator top level in place of the fixed array and is fed by the operand staging buffers.

## Interface
- LANES, 4: number of parallel MAC lanes.
- DATA_W, 8: signed operand width.
- ACC_W, 32: signed accumulator width; must be ≥ 2*DATA_W.
- K_W, 8: width of k_len; maximum dot-product length is 2^K_W − 1.

- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  job request, sampled only in IDLE.
- k_len  in  K_W  beats per job, sampled with start.
- busy  out  1  high in every state except IDLE.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat; high only in ACC.
- a_vec  in  LANES*DATA_W  lane i operand A at [i*DATA_W +: DATA_W], signed.
- b_vec  in  LANES*DATA_W  lane i operand B, same packing.
- out_valid  out  1  results valid; high only in DONE.
- out_ready  in  1  consumer accepts results.
- acc_vec  out  LANES*ACC_W  lane i result at [i*ACC_W +: ACC_W].
- ovf  out  LANES  per-lane sticky overflow flag.

## Operation
- FSM states: IDLE, ACC, DONE.
- IDLE: on start=1, clear all accumulators and ovf, latch k_len into the beat counter. If k_len≠0, go to ACC; if k_len=0, go to DONE with zero results.
- ACC: a beat is accepted when in_valid && in_ready. Per lane, acc += sext(a_i*b_i). The product is a full 2*DATA_W signed product, sign-extended to ACC_W. The counter decrements per accepted beat. Acceptance of the final beat moves the FSM to DONE. in_valid=0 stalls with no state change.
- DONE: acc_vec and ovf are held stable while out_valid=1. On out_ready=1, go to IDLE.
- start is ignored in ACC and DONE. A start asserted in the same cycle as the DONE→IDLE handshake is ignored; it is accepted on the next cycle if still high.
- Reset, including mid-job: FSM goes to IDLE, counter and accumulators clear, any partially accumulated job is discarded.
- acc_vec is driven from the accumulator registers in every state. Its value is only meaningful while out_valid=1.

## Timing
- Reset values: busy=0, in_ready=0, out_valid=0, acc_vec=0, ovf=0.
- start→in_ready: one cycle. in_ready rises in the cycle after start is sampled.
- Throughput: one beat per cycle, with no bubbles while in_valid stays high.
- Last accepted beat→out_valid: one cycle, and acc_vec includes that beat.
- Job latency with continuous input: k_len+1 cycles from start sample to out_valid. With k_len=0: out_valid rises 1 cycle after start.
- in_ready does not depend combinationally on in_valid. out_valid does not depend on out_ready.
- Back-to-back jobs: minimum 1 IDLE cycle between the output handshake and the next start acceptance.

## Configuration
- MAC_SATURATE_EN defined:
  - Each lane update saturates to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
  - ovf[i] sets on any clamp and stays set until the next start or rst.
  - Saturation is judged on the exact sum, meaning accumulator plus sign-extended product with one guard bit.
- MAC_SATURATE_EN undefined:
  - Accumulation wraps modulo 2^ACC_W.
  - ovf is tied to 0.

## Test plan
- Reset, then start with k_len=3 and beats (a,b) per lane 0..3 = (1,2),(−3,4),(127,127),(−128,−128) repeated on all 3 beats -> after 4 cycles out_valid=1, acc = 6, −36, 48387, 49152; busy drops after out_ready.
- Same job with in_valid toggling 1,0,1,0,1 -> same results. out_valid rises one cycle after the 3rd accepted beat. in_ready stays high throughout ACC.
- k_len=0 -> out_valid one cycle after start, all acc=0, ovf=0. start pulses during DONE are ignored.
- ACC_W=16, k_len=3, all lanes (127,127) -> MAC_SATURATE_EN: acc=32767, ovf=4'hF. Without the macro: acc=48387 mod 2^16 as signed = −17149, ovf=0.
- rst asserted after 2 of 5 beats -> next cycle busy=0, acc=0. A new job with k_len=1 and (2,3) returns 6 on every lane.
- out_ready held low for 10 cycles in DONE -> acc_vec and ovf are stable, in_ready=0, and start is ignored. Releasing out_ready returns to IDLE, and a start held high is accepted on the following cycle.

Source files
------------

// File: rtl/mac_array_stream.sv
// Handshaked LANES-wide signed MAC array: one operand beat per accepted cycle, results via valid/ready.
// Optional feature: define MAC_SATURATE_EN for saturating accumulation with sticky per-lane ovf.
module mac_array_stream #(
    parameter int LANES  = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int K_W    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [K_W-1:0]          k_len,
    output logic                    busy,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] a_vec,
    input  logic [LANES*DATA_W-1:0] b_vec,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*ACC_W-1:0]  acc_vec,
    output logic [LANES-1:0]        ovf
);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t           state, state_next;
    logic [K_W-1:0]   cnt;
    logic [ACC_W-1:0] acc      [LANES];
    logic [ACC_W-1:0] acc_next [LANES];
    logic [LANES-1:0] clamp;
    logic [LANES-1:0] ovf_r;
    logic             beat;

    assign busy      = (state != IDLE);
    assign in_ready  = (state == ACC);
    assign out_valid = (state == DONE);
    assign beat      = in_valid && in_ready;
    assign ovf       = ovf_r;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (k_len == '0) ? DONE : ACC;
            ACC:     if (beat && cnt == K_W'(1)) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [2*DATA_W-1:0] prod;
        assign prod = $signed(a_vec[g*DATA_W +: DATA_W]) * $signed(b_vec[g*DATA_W +: DATA_W]);
`ifdef MAC_SATURATE_EN
        // One guard bit holds the exact sum; a mismatch between the top two bits means a clamp.
        logic [ACC_W:0] sum;
        assign sum = {acc[g][ACC_W-1], acc[g]}
                   + {{(ACC_W+1-2*DATA_W){prod[2*DATA_W-1]}}, prod};
        assign clamp[g]    = sum[ACC_W] ^ sum[ACC_W-1];
        assign acc_next[g] = !clamp[g]   ? sum[ACC_W-1:0]
                           : sum[ACC_W]  ? {1'b1, {(ACC_W-1){1'b0}}}
                                         : {1'b0, {(ACC_W-1){1'b1}}};
`else
        assign clamp[g]    = 1'b0;
        assign acc_next[g] = acc[g] + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
`endif
        assign acc_vec[g*ACC_W +: ACC_W] = acc[g];
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            ovf_r <= '0;
            // NOTE: the accumulator array is reset explicitly because a reset must discard any partial job.
            for (int i = 0; i < LANES; i++) acc[i] <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (start) begin
                    cnt   <= k_len;
                    ovf_r <= '0;
                    for (int i = 0; i < LANES; i++) acc[i] <= '0;
                end
                ACC: if (beat) begin
                    cnt   <= cnt - K_W'(1);
                    ovf_r <= ovf_r | clamp;
                    for (int i = 0; i < LANES; i++) acc[i] <= acc_next[i];
                end
                default: ;
            endcase
        end
    end

endmodule
